uiarp_rx_mip: RTL and testbench

ARP receive parser, successor to the single-address ARP RX block. Sits between the ip_arp_rx demux and the ARP TX / MAC-cache modules, like its predecessor.
- Adds N local IP addresses with per-entry enable, optional header validation, gratuitous-ARP learning and address-conflict detection.
- Adds explicit drain of trailer/padding bytes, truncation/error handling, and saturating statistics counters.

---
 rtl/uiarp_rx_mip.sv | 160 ++++++++++++++++
 tb/tb_uiarp_rx_mip.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uiarp_rx_mip.sv
// uiarp_rx_mip: ARP receive parser with N local IPs, header validation,
// gratuitous-ARP learning, address-conflict detection and saturating counters.
//
// Ports:
//   I_arp_clk, I_arp_rstn          clock, asynchronous active-low reset
//   I_ip_local_addr / _en          local IPv4 table (entry i at [32*i+31:32*i]) and enables
//   I_arp_rvalid / I_arp_rdata     ARP payload byte stream, network order
//   O_arp_req_*                    pulse + SPA/SHA/index for a request to a local IP
//   O_arp_reply_*                  pulse + SPA/SHA for a reply or gratuitous ARP to learn
//   O_arp_conflict                 pulse when a sender claims one of our enabled IPs
//   O_rx_ok_cnt / O_rx_err_cnt     saturating frame statistics
`timescale 1ns/1ps
module uiarp_rx_mip #(
    parameter int N_IP      = 4,
    parameter int IDX_W     = 2,
    parameter int CHECK_HDR = 1,
    parameter int GRAT_EN   = 1,
    parameter int CNT_W     = 16
) (
    input  logic                I_arp_clk,
    input  logic                I_arp_rstn,
    input  logic [32*N_IP-1:0]  I_ip_local_addr,
    input  logic [N_IP-1:0]     I_ip_local_en,
    input  logic                I_arp_rvalid,
    input  logic [7:0]          I_arp_rdata,
    output logic                O_arp_req_valid,
    output logic [31:0]         O_arp_req_ip_addr,
    output logic [47:0]         O_arp_req_mac_addr,
    output logic [IDX_W-1:0]    O_arp_req_idx,
    output logic                O_arp_reply_done,
    output logic [31:0]         O_arp_reply_ip_addr,
    output logic [47:0]         O_arp_reply_mac_addr,
    output logic                O_arp_conflict,
    output logic [CNT_W-1:0]    O_rx_ok_cnt,
    output logic [CNT_W-1:0]    O_rx_err_cnt
);
    typedef enum logic [1:0] {IDLE, PARSE, CHECK, DRAIN} state_t;

    state_t         state;
    logic [4:0]     cnt;
    // 28-byte payload shifted in MSB-first, so byte 0 ends at the top
    logic [223:0]   frame;

    logic [15:0]    htype, ptype, oper;
    logic [7:0]     hlen, plen;
    logic [47:0]    sha;
    logic [31:0]    spa, tpa;
    logic           spa_local, tpa_hit, frame_err, is_conf, is_req, is_rep;
    logic [IDX_W-1:0] tpa_idx;

    assign htype = frame[223:208];
    assign ptype = frame[207:192];
    assign hlen  = frame[191:184];
    assign plen  = frame[183:176];
    assign oper  = frame[175:160];
    assign sha   = frame[159:112];
    assign spa   = frame[111:80];
    assign tpa   = frame[31:0];

    // Descending scan so the lowest matching entry wins the index
    always_comb begin
        spa_local = 1'b0;
        tpa_hit   = 1'b0;
        tpa_idx   = '0;
        for (int i = N_IP - 1; i >= 0; i--) begin
            if (I_ip_local_en[i] && I_ip_local_addr[32*i +: 32] == spa)
                spa_local = 1'b1;
            if (I_ip_local_en[i] && I_ip_local_addr[32*i +: 32] == tpa) begin
                tpa_hit = 1'b1;
                tpa_idx = IDX_W'(i);
            end
        end
    end

    // OPER is always validated; the fixed header fields only when CHECK_HDR is set
    always_comb begin
        frame_err = (oper != 16'd1 && oper != 16'd2) ||
                    (CHECK_HDR != 0 && (htype != 16'h0001 || ptype != 16'h0800 ||
                                        hlen != 8'd6 || plen != 8'd4));
        is_conf   = !frame_err && spa_local;
        is_req    = !frame_err && !spa_local && oper == 16'd1 && tpa_hit;
        is_rep    = !frame_err && !spa_local && !is_req &&
                    (oper == 16'd2 || (oper == 16'd1 && spa == tpa && GRAT_EN != 0));
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge I_arp_clk or negedge I_arp_rstn) begin
        if (!I_arp_rstn) begin
            state                <= IDLE;
            cnt                  <= '0;
            frame                <= '0;
            O_arp_req_valid      <= 1'b0;
            O_arp_req_ip_addr    <= '0;
            O_arp_req_mac_addr   <= '0;
            O_arp_req_idx        <= '0;
            O_arp_reply_done     <= 1'b0;
            O_arp_reply_ip_addr  <= '0;
            O_arp_reply_mac_addr <= '0;
            O_arp_conflict       <= 1'b0;
            O_rx_ok_cnt          <= '0;
            O_rx_err_cnt         <= '0;
        end else begin
            O_arp_req_valid  <= 1'b0;
            O_arp_reply_done <= 1'b0;
            O_arp_conflict   <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_arp_rvalid) begin
                        frame <= {216'b0, I_arp_rdata};
                        cnt   <= 5'd1;
                        state <= PARSE;
                    end
                end
                PARSE: begin
                    if (I_arp_rvalid) begin
                        frame <= {frame[215:0], I_arp_rdata};
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd27)
                            state <= CHECK;
                    end else begin
                        // any gap before byte 27 is a truncated frame
                        O_rx_err_cnt <= sat_inc(O_rx_err_cnt);
                        frame        <= '0;
                        cnt          <= '0;
                        state        <= IDLE;
                    end
                end
                CHECK: begin
                    O_arp_conflict   <= is_conf;
                    O_arp_req_valid  <= is_req;
                    O_arp_reply_done <= is_rep;
                    if (frame_err)
                        O_rx_err_cnt <= sat_inc(O_rx_err_cnt);
                    if (is_conf || is_req || is_rep)
                        O_rx_ok_cnt <= sat_inc(O_rx_ok_cnt);
                    if (is_req) begin
                        O_arp_req_ip_addr  <= spa;
                        O_arp_req_mac_addr <= sha;
                        O_arp_req_idx      <= tpa_idx;
                    end
                    if (is_rep) begin
                        O_arp_reply_ip_addr  <= spa;
                        O_arp_reply_mac_addr <= sha;
                    end
                    frame <= '0;
                    cnt   <= '0;
                    state <= I_arp_rvalid ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (!I_arp_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uiarp_rx_mip.sv
// tb_uiarp_rx_mip: self-checking bench for uiarp_rx_mip. Four instances share the
// input stream: defaults, CHECK_HDR=0, GRAT_EN=0, and a 4-bit-counter variant.
`timescale 1ns/1ps
module tb_uiarp_rx_mip;
    localparam int K_NONE = 0, K_ERR = 1, K_CONF = 2, K_REQ = 3, K_REP = 4, K_TRUNC = 5;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [127:0] laddr = {32'hC0A8010D, 32'hC0A8010C, 32'hC0A8010B, 32'hC0A8010A};
    logic [3:0]   len = 4'hF;
    logic         rvalid = 1'b0;
    logic [7:0]   rdata = 8'h00;
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    logic         rq [4];
    logic         rp [4];
    logic         cf [4];
    logic [31:0]  rq_ip [4];
    logic [47:0]  rq_mac [4];
    logic [1:0]   rq_idx [4];
    logic [31:0]  rp_ip [4];
    logic [47:0]  rp_mac [4];
    logic [15:0]  okc [4];
    logic [15:0]  errc [4];

    // reference model state
    int           m_ok [4];
    int           m_err [4];
    logic [31:0]  m_rq_ip [4];
    logic [47:0]  m_rq_mac [4];
    logic [1:0]   m_rq_idx [4];
    logic [31:0]  m_rp_ip [4];
    logic [47:0]  m_rp_mac [4];
    int           exp_cyc [4];
    int           exp_kind [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : u
        localparam int CW = (g == 3) ? 4 : 16;
        logic [CW-1:0] ok_c, err_c;
        uiarp_rx_mip #(.N_IP(4), .IDX_W(2), .CHECK_HDR(g == 1 ? 0 : 1),
                       .GRAT_EN(g == 2 ? 0 : 1), .CNT_W(CW)) dut (
            .I_arp_clk(clk), .I_arp_rstn(rstn),
            .I_ip_local_addr(laddr), .I_ip_local_en(len),
            .I_arp_rvalid(rvalid), .I_arp_rdata(rdata),
            .O_arp_req_valid(rq[g]), .O_arp_req_ip_addr(rq_ip[g]),
            .O_arp_req_mac_addr(rq_mac[g]), .O_arp_req_idx(rq_idx[g]),
            .O_arp_reply_done(rp[g]), .O_arp_reply_ip_addr(rp_ip[g]),
            .O_arp_reply_mac_addr(rp_mac[g]), .O_arp_conflict(cf[g]),
            .O_rx_ok_cnt(ok_c), .O_rx_err_cnt(err_c));
        assign okc[g]  = 16'(ok_c);
        assign errc[g] = 16'(err_c);
    end

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    function automatic int cmax(input int k);
        return (k == 3) ? 15 : 65535;
    endfunction

    function automatic logic [223:0] mk(input logic [15:0] ptype, input logic [15:0] oper,
                                        input logic [47:0] sha, input logic [31:0] spa,
                                        input logic [31:0] tpa);
        return {16'h0001, ptype, 8'd6, 8'd4, oper, sha, spa, 48'h0, tpa};
    endfunction

    // Decision rules taken straight from the protocol description, in priority order
    function automatic void model(input logic [223:0] f, input int k, output int kind, output logic [1:0] idx);
        logic [15:0] ht = f[223:208];
        logic [15:0] pt = f[207:192];
        logic [7:0]  hl = f[191:184];
        logic [7:0]  pl = f[183:176];
        logic [15:0] op = f[175:160];
        logic [31:0] spa = f[111:80];
        logic [31:0] tpa = f[31:0];
        bit spa_loc = 0;
        bit tpa_loc = 0;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (len[i] && laddr[32*i +: 32] == spa) spa_loc = 1;
            if (!tpa_loc && len[i] && laddr[32*i +: 32] == tpa) begin
                tpa_loc = 1;
                idx = 2'(i);
            end
        end
        if ((op != 1 && op != 2) || (k != 1 && (ht != 1 || pt != 16'h0800 || hl != 6 || pl != 4)))
            kind = K_ERR;
        else if (spa_loc)
            kind = K_CONF;
        else if (op == 1 && tpa_loc)
            kind = K_REQ;
        else if (op == 2)
            kind = K_REP;
        else if (op == 1 && spa == tpa && k != 2)
            kind = K_REP;
        else
            kind = K_NONE;
    endfunction

    task automatic expect_frame(input int k, input int kind, input logic [1:0] idx, input logic [223:0] f);
        exp_cyc[k]  = cyc + 2;
        exp_kind[k] = kind;
        if (kind == K_ERR) m_err[k] = (m_err[k] < cmax(k)) ? m_err[k] + 1 : m_err[k];
        if (kind == K_CONF || kind == K_REQ || kind == K_REP)
            m_ok[k] = (m_ok[k] < cmax(k)) ? m_ok[k] + 1 : m_ok[k];
        if (kind == K_REQ) begin
            m_rq_ip[k] = f[111:80]; m_rq_mac[k] = f[159:112]; m_rq_idx[k] = idx;
        end
        if (kind == K_REP) begin
            m_rp_ip[k] = f[111:80]; m_rp_mac[k] = f[159:112];
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_ok[k] = 0; m_err[k] = 0; m_rq_ip[k] = 0; m_rq_mac[k] = 0; m_rq_idx[k] = 0;
            m_rp_ip[k] = 0; m_rp_mac[k] = 0; exp_cyc[k] = -1; exp_kind[k] = K_NONE;
        end
    endtask

    // Pulse monitor: every cycle each pulse must match the expected one-cycle event
    always @(negedge clk) begin
        if (rstn) begin
            for (int k = 0; k < 4; k++) begin
                logic [2:0] e;
                e = 3'b000;
                if (cyc == exp_cyc[k])
                    e = (exp_kind[k] == K_REQ) ? 3'b100 : (exp_kind[k] == K_REP) ? 3'b010 :
                        (exp_kind[k] == K_CONF) ? 3'b001 : 3'b000;
                chk("pulses{req,rep,conf}", k, 64'({rq[k], rp[k], cf[k]}), 64'(e));
            end
        end
    end

    task automatic checkpoint();
        for (int k = 0; k < 4; k++) begin
            chk("pulses_idle", k, 64'({rq[k], rp[k], cf[k]}), 64'(0));
            chk("req_ip", k, 64'(rq_ip[k]), 64'(m_rq_ip[k]));
            chk("req_mac", k, 64'(rq_mac[k]), 64'(m_rq_mac[k]));
            chk("req_idx", k, 64'(rq_idx[k]), 64'(m_rq_idx[k]));
            chk("reply_ip", k, 64'(rp_ip[k]), 64'(m_rp_ip[k]));
            chk("reply_mac", k, 64'(rp_mac[k]), 64'(m_rp_mac[k]));
            chk("ok_cnt", k, 64'(okc[k]), 64'(m_ok[k]));
            chk("err_cnt", k, 64'(errc[k]), 64'(m_err[k]));
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        rvalid = v;
        rdata  = d;
    endtask

    // tk >= 0 overrides the model's verdict for instance 0 with a hand-derived one
    task automatic send(input logic [223:0] f, input int nb, input int pad, input int idle,
                        input int tk, input logic [1:0] tidx);
        int kind;
        logic [1:0] idx;
        for (int i = 0; i < nb; i++) begin
            drive(1'b1, f[223-8*i -: 8]);
            if (i == 27) begin
                for (int k = 0; k < 4; k++) begin
                    model(f, k, kind, idx);
                    if (k == 0 && tk >= 0) begin
                        kind = tk;
                        idx  = tidx;
                    end
                    expect_frame(k, kind, idx, f);
                end
            end
        end
        if (nb < 28)
            for (int k = 0; k < 4; k++) m_err[k] = (m_err[k] < cmax(k)) ? m_err[k] + 1 : m_err[k];
        for (int i = 0; i < pad; i++) drive(1'b1, 8'($urandom));
        for (int i = 0; i < idle; i++) drive(1'b0, 8'h00);
        if (idle >= 3) begin
            @(negedge clk);
            checkpoint();
        end
    endtask

    typedef struct {
        logic [3:0]  en;
        logic [15:0] ptype;
        logic [15:0] oper;
        logic [31:0] spa;
        logic [31:0] tpa;
        logic [47:0] sha;
        int          nb;
        int          pad;
        int          idle;
        int          kind;
        logic [1:0]  idx;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tv[14];
        logic [223:0] f;
        logic [31:0] pool[6];
        tv[0]  = '{4'hF, 16'h0800, 16'd1, 32'hC0A80102, 32'hC0A8010C, 48'h000A35010203, 28, 0, 3, K_REQ, 2'd2};
        tv[1]  = '{4'hF, 16'h0800, 16'd2, 32'hC0A80132, 32'h0A000001, 48'h0200000000AA, 28, 0, 3, K_REP, 2'd0};
        tv[2]  = '{4'hF, 16'h0800, 16'd1, 32'hC0A80103, 32'hC0A8010A, 48'h000A35AABBCC, 28, 18, 1, K_REQ, 2'd0};
        tv[3]  = '{4'hF, 16'h0800, 16'd1, 32'hC0A80104, 32'hC0A8010B, 48'h000A35DDEEFF, 28, 0, 3, K_REQ, 2'd1};
        tv[4]  = '{4'hF, 16'h0800, 16'd1, 32'hC0A80105, 32'hC0A8010C, 48'h111111111111, 15, 0, 3, K_TRUNC, 2'd0};
        tv[5]  = '{4'hF, 16'h86DD, 16'd1, 32'hC0A80106, 32'hC0A8010C, 48'h222222222222, 28, 0, 3, K_ERR, 2'd0};
        tv[6]  = '{4'hF, 16'h0800, 16'd1, 32'hC0A8010B, 32'hC0A8010C, 48'h333333333333, 28, 0, 3, K_CONF, 2'd0};
        tv[7]  = '{4'hF, 16'h0800, 16'd1, 32'hC0A8014D, 32'hC0A8014D, 48'h444444444444, 28, 0, 3, K_REP, 2'd0};
        tv[8]  = '{4'hB, 16'h0800, 16'd1, 32'hC0A80107, 32'hC0A8010C, 48'h555555555555, 28, 0, 3, K_NONE, 2'd0};
        tv[9]  = '{4'hB, 16'h0800, 16'd2, 32'hC0A8010C, 32'hC0A80101, 48'h666666666666, 28, 0, 3, K_REP, 2'd0};
        tv[10] = '{4'hB, 16'h0800, 16'd1, 32'hC0A80108, 32'hC0A8010D, 48'h777777777777, 28, 0, 3, K_REQ, 2'd3};
        tv[11] = '{4'hF, 16'h0800, 16'd3, 32'hC0A80109, 32'hC0A8010C, 48'h888888888888, 28, 0, 3, K_ERR, 2'd0};
        tv[12] = '{4'hF, 16'h0800, 16'd1, 32'hC0A80105, 32'h0A000001, 48'h999999999999, 28, 0, 3, K_NONE, 2'd0};
        tv[13] = '{4'hF, 16'h0800, 16'd2, 32'hC0A8010A, 32'hC0A80101, 48'hAAAAAAAAAAAA, 28, 2, 3, K_CONF, 2'd0};

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkpoint();
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // directed table
        foreach (tv[i]) begin
            len = tv[i].en;
            send(mk(tv[i].ptype, tv[i].oper, tv[i].sha, tv[i].spa, tv[i].tpa),
                 tv[i].nb, tv[i].pad, tv[i].idle, tv[i].kind, tv[i].idx);
        end
        len = 4'hF;

        // asynchronous reset in the middle of a frame (during byte 20)
        f = mk(16'h0800, 16'd1, 48'hABCDEF012345, 32'hC0A80120, 32'hC0A8010D);
        for (int i = 0; i <= 20; i++) drive(1'b1, f[223-8*i -: 8]);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        checkpoint();
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        rstn = 1'b1;
        drive(1'b0, 8'h00);
        send(f, 28, 0, 3, K_REQ, 2'd3);

        // enough accepted frames to saturate the 4-bit counter variant
        for (int i = 0; i < 18; i++)
            send(mk(16'h0800, 16'd2, 48'h0000AA000000 + 48'(i), 32'h0A000100 + 32'(i), 32'h0A000001),
                 28, 0, 3, -1, 2'd0);
        for (int i = 0; i < 17; i++)
            send(mk(16'h0800, 16'd1, 48'h1, 32'h0A000200, 32'hC0A8010A), 9, 0, 3, -1, 2'd0);

        // randomized frames against the reference model
        pool = '{32'hC0A8010A, 32'hC0A8010B, 32'hC0A8010C, 32'hC0A8010D, 32'hC0A8014D, 32'h0A000009};
        for (int n = 0; n < 60; n++) begin
            logic [15:0] op;
            logic [31:0] spa, tpa;
            int nb;
            op  = ($urandom % 8 == 0) ? 16'd3 : ($urandom % 2 == 1) ? 16'd1 : 16'd2;
            spa = ($urandom % 5 == 0) ? $urandom : pool[$urandom % 6];
            tpa = ($urandom % 4 == 0) ? spa : pool[$urandom % 6];
            nb  = ($urandom % 8 == 0) ? int'($urandom_range(1, 27)) : 28;
            len = ($urandom % 3 == 0) ? 4'($urandom) : 4'hF;
            send(mk(($urandom % 6 == 0) ? 16'h86DD : 16'h0800, op,
                    {16'h0002, 32'($urandom)}, spa, tpa),
                 nb, (nb < 28) ? 0 : int'($urandom_range(0, 4)), 3, -1, 2'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
